// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-to-binary converter.
// Holds the default code-word width and a population-count helper used by
// the optional adjacency checker (enabled by the GRAY_STEP_CHECK_EN macro).
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  // Number of set bits in a 32-bit word; callers zero-extend narrower words.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_to_binary_behavioral_spec_gray2bin_comb.sv
// Combinational reflected-binary Gray to natural binary conversion.
// Each binary bit is the XOR of all Gray bits at or above its position.
// Ports:
//   gray   - WIDTH-bit Gray code word
//   binary - WIDTH-bit natural binary value (purely combinational)
module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  // Running prefix XOR from the MSB downward; kept in a local variable so
  // the block never reads back its own output.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    binary = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc       = acc ^ gray[i];
      binary[i] = acc;
    end
  end

endmodule

// File: rtl/gray_to_binary_behavioral_spec.sv
// Registered Gray-to-binary converter with one cycle of latency.
// Optional feature: define GRAY_STEP_CHECK_EN to add the step_err output,
// which flags a valid word differing from the previous valid word in two
// or more bit positions.
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - synchronous active-high reset
//   in_valid  - gray is valid this cycle
//   gray      - WIDTH-bit Gray code input
//   out_valid - binary holds a fresh result this cycle
//   binary    - registered binary result, held while no new word arrives
//   step_err  - (GRAY_STEP_CHECK_EN only) adjacency violation, aligned with out_valid
module gray_to_binary_behavioral_spec
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray,
`ifdef GRAY_STEP_CHECK_EN
  output logic             step_err,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] binary
);

  logic [WIDTH-1:0] bin_p0;
  logic [WIDTH-1:0] binary_p1;
  logic             vld_p1;

  gray2bin_comb #(.WIDTH(WIDTH)) u_conv (
    .gray   (gray),
    .binary (bin_p0)
  );

  // Stage p0 -> p1: capture converted word and its valid.
  // Reset wins over in_valid, so a word presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      binary_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        binary_p1 <= bin_p0;
      end
    end
  end

  assign binary    = binary_p1;
  assign out_valid = vld_p1;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_p1;
  logic             hist_vld_p1;
  logic             step_err_p1;
  logic [31:0]      diff_p0;
  logic             far_p0;

  always_comb begin
    diff_p0              = '0;
    diff_p0[WIDTH-1:0]   = gray ^ prev_p1;
    far_p0               = (popcount(diff_p0) >= 32'd2);
  end

  // Stage p0 -> p1: history register and flag. Clearing hist_vld_p1 on
  // reset is enough to keep the first post-reset word from being flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_p1 <= 1'b0;
      step_err_p1 <= 1'b0;
    end else begin
      step_err_p1 <= in_valid && hist_vld_p1 && far_p0;
      if (in_valid) begin
        hist_vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      prev_p1 <= gray;
    end
  end

  assign step_err = step_err_p1;
`endif

endmodule

// File: tb/tb_gray_to_binary_behavioral_spec.sv
// Directed bench for the Gray-to-binary converter: a WIDTH=4 instance driven
// from a vector table plus reset corner sequences, and a WIDTH=8 instance
// swept over all codes back to back. step_err checks are compiled in only
// when GRAY_STEP_CHECK_EN is defined.
module tb_gray_to_binary_behavioral_spec;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid4, in_valid8;
  logic [3:0] gray4;
  logic [7:0] gray8;
  logic       out_valid4, out_valid8;
  logic [3:0] binary4;
  logic [7:0] binary8;
`ifdef GRAY_STEP_CHECK_EN
  logic       step_err4, step_err8;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_to_binary_behavioral_spec #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .gray      (gray4),
`ifdef GRAY_STEP_CHECK_EN
    .step_err  (step_err4),
`endif
    .out_valid (out_valid4),
    .binary    (binary4)
  );

  gray_to_binary_behavioral_spec #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .gray      (gray8),
`ifdef GRAY_STEP_CHECK_EN
    .step_err  (step_err8),
`endif
    .out_valid (out_valid8),
    .binary    (binary8)
  );

  typedef struct {
    logic       vld;
    logic [3:0] g;
    logic [3:0] exp_bin;
    logic       exp_vld;
    logic       exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    // {valid, gray, expected binary, expected out_valid, expected step_err}
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b0011, 4'b0010, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b0010, 4'b0011, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0011, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0011, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0011, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0110, 4'b0100, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0111, 4'b0101, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0100, 4'b0111, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 4'b1111, 4'b1010, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 4'b1111, 4'b1010, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid4 = 1'b0; in_valid8 = 1'b0; gray4 = '0; gray8 = '0;
    tick(); tick();
    check("reset_binary4", 32'(binary4), 32'd0);
    check("reset_vld4", 32'(out_valid4), 32'd0);
    check("reset_binary8", 32'(binary8), 32'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("reset_err4", 32'(step_err4), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      in_valid4 = vecs[i].vld;
      gray4     = vecs[i].g;
      tick();
      check($sformatf("vec%0d_binary", i), 32'(binary4), 32'(vecs[i].exp_bin));
      check($sformatf("vec%0d_vld", i), 32'(out_valid4), 32'(vecs[i].exp_vld));
`ifdef GRAY_STEP_CHECK_EN
      check($sformatf("vec%0d_err", i), 32'(step_err4), 32'(vecs[i].exp_err));
`endif
    end

    // Reset collides with a valid word: the word must be discarded.
    rst = 1'b1; in_valid4 = 1'b1; gray4 = 4'b1111;
    tick();
    check("rstcol_binary", 32'(binary4), 32'd0);
    check("rstcol_vld", 32'(out_valid4), 32'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("rstcol_err", 32'(step_err4), 32'd0);
`endif
    rst = 1'b0; in_valid4 = 1'b1; gray4 = 4'b1000;
    tick();
    check("postrst_binary", 32'(binary4), 32'b1111);
    check("postrst_vld", 32'(out_valid4), 32'd1);
`ifdef GRAY_STEP_CHECK_EN
    check("postrst_err", 32'(step_err4), 32'd0);
`endif
    gray4 = 4'b1001;
    tick();
    check("postrst2_binary", 32'(binary4), 32'b1110);
`ifdef GRAY_STEP_CHECK_EN
    check("postrst2_err", 32'(step_err4), 32'd0);
`endif
    gray4 = 4'b0110;
    tick();
    check("postrst3_binary", 32'(binary4), 32'b0100);
`ifdef GRAY_STEP_CHECK_EN
    check("postrst3_err", 32'(step_err4), 32'd1);
`endif
    in_valid4 = 1'b0;
    tick();
    check("idle_vld", 32'(out_valid4), 32'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("idle_err", 32'(step_err4), 32'd0);
`endif

    // WIDTH=8 exhaustive sweep, back to back with no gaps.
    for (int i = 0; i < 256; i++) begin
      in_valid8 = 1'b1;
      gray8     = 8'(i);
      tick();
      check($sformatf("w8_%0d_binary", i), 32'(binary8), 32'(model8(8'(i))));
      check($sformatf("w8_%0d_vld", i), 32'(out_valid8), 32'd1);
    end
    in_valid8 = 1'b0;
    tick();
    check("w8_hold_binary", 32'(binary8), 32'(model8(8'd255)));
    check("w8_hold_vld", 32'(out_valid8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
